// File: rtl/store_pkg.sv
// Shared types and helpers for the store merge unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package store_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_RD,
    WRITE,
    DONE
  } state_t;

  // Store size codes carried in funct3
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  // One bit per byte lane written by a store of 2**size_log2 bytes at offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size_log2,
                                           input logic [2:0] offset);
    logic [7:0] base;
    case (size_log2)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/store_byte_merge.sv
// Byte-lane merge of right-aligned store data into a read memory word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: size_log2 (log2 of store bytes), offset (byte lane of first byte),
//        store_data (low bytes valid), mem_rdata (old word) -> merged (new word).
module store_byte_merge
  import store_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]                    size_log2,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [DATA_W-1:0]             store_data,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W-1:0]             merged
);

  localparam int BYTES = DATA_W / 8;

  logic [7:0]        lanes;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] bmask;

  assign lanes   = lane_mask(size_log2, 3'(offset));
  // Move the low store bytes up to the addressed lane; bytes that slide past
  // the mask are discarded below.
  assign shifted = store_data << {offset, 3'b000};

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign bmask[i*8 +: 8] = {8{lanes[i]}};
  end

  assign merged = (shifted & bmask) | (mem_rdata & ~bmask);

endmodule

// File: rtl/store_merge_unit.sv
// Read-modify-write engine turning byte/half/word/double stores into word writes.
// Latency: full-width accept->write 1 cycle, done 2; sub-word read at 1, write 1 after rvalid, done 1 later.
// Backpressure: req_ready low while busy; WAIT_RD stalls indefinitely on mem_rvalid.
// Ports: clk, reset (async active-high); req_valid/req_ready/funct3/addr/store_data request side;
//        mem_addr/mem_rd_en/mem_rdata/mem_rvalid/mem_wr_en/mem_wdata memory side; done, busy status.
// Build option STORE_MISALIGN_TRAP_EN: misaligned stores complete without memory access and
// raise the extra misalign output during DONE; otherwise misaligned stores are aligned down.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              busy
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  state_t            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              full_in;
  logic [OFF_W-1:0]  off_al;

  // Stores at least as wide as the memory word (or reserved codes) skip the read.
  function automatic logic is_full(input logic [2:0] f3);
    return f3[2] || (f3[1:0] == SD[1:0]) || ((DATA_W == 32) && (f3[1:0] == SW[1:0]));
  endfunction

  // Offset bits below the store's natural alignment.
  function automatic logic [OFF_W-1:0] size_m1(input logic [1:0] size_log2);
    logic [3:0] m;
    m = (4'd1 << size_log2) - 4'd1;
    return m[OFF_W-1:0];
  endfunction

  assign accept  = req_valid && (state_q == IDLE);
  assign full_in = is_full(funct3);
  assign off_al  = addr_q[OFF_W-1:0] & ~size_m1(funct3_q[1:0]);

`ifdef STORE_MISALIGN_TRAP_EN
  logic mis_in;
  logic mis_q;
  assign mis_in = (addr[OFF_W-1:0] & size_m1(funct3[1:0])) != '0;
`endif

  store_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .size_log2  (funct3_q[1:0]),
    .offset     (off_al),
    .store_data (data_q),
    .mem_rdata  (mem_rdata),
    .merged     (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef STORE_MISALIGN_TRAP_EN
          if (mis_in)       state_d = DONE;
          else if (full_in) state_d = WRITE;
          else              state_d = READ;
`else
          if (full_in) state_d = WRITE;
          else         state_d = READ;
`endif
        end
      end
      READ:    state_d = WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (accept) begin
        funct3_q <= funct3;
        addr_q   <= addr;
        data_q   <= store_data;
        // Full-width data goes straight to the write register.
        if (full_in) wdata_q <= store_data;
      end
      if ((state_q == WAIT_RD) && mem_rvalid) wdata_q <= merged;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       mis_q <= 1'b0;
    else if (accept) mis_q <= mis_in;
  end
  assign misalign = (state_q == DONE) && mis_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_rd_en = (state_q == READ);
  assign mem_wr_en = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit (DATA_W=64) with a write-data scoreboard.
// Latency: n/a.
// Backpressure: bench drives mem_rvalid with programmable delay.
module tb_store_merge_unit;
  import store_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic [63:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr_en;
  logic [63:0] mem_wdata;
  logic        done;
  logic        busy;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misalign;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  store_merge_unit #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .busy       (busy)
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
    if (done)      done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference merge: walk the store bytes one at a time into the old word.
  function automatic logic [63:0] ref_merge(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] d, input logic [63:0] old);
    int n, off;
    logic [63:0] r;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    off = off - (off % n);
    r   = old;
    for (int i = 0; i < n; i++) r[(off + i) * 8 +: 8] = d[i * 8 +: 8];
    return r;
  endfunction

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] rd, input int rdelay,
                          input bit hold, input bit sub, input bit trap);
    int rd_cyc, wr_cyc, done_cyc, rv_cyc;
    logic [63:0] exp_addr;
    rd_cyc = -1; wr_cyc = -1; done_cyc = -1; rv_cyc = -1;
    exp_addr = {a[63:3], 3'b000};
    @(negedge clk);
    chk({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; funct3 = f3; addr = a; store_data = d;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = rd;
      chk({tag, " busy"}, {62'd0, busy, req_ready}, 64'd2);
      chk({tag, " addr"}, mem_addr, exp_addr);
      if (mem_rd_en && rd_cyc < 0) rd_cyc = cyc;
      if (mem_wr_en) begin
        wr_cyc = cyc;
        if (exp_q.size() == 0) chk({tag, " unexpected write"}, 64'd1, 64'd0);
        else chk({tag, " wdata"}, mem_wdata, exp_q.pop_front());
      end
`ifdef STORE_MISALIGN_TRAP_EN
      chk({tag, " misalign"}, 64'(misalign), 64'(trap && done));
`endif
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (rd_cyc > 0 && cyc == rd_cyc && rdelay > 0) begin
        // Stray rvalid with junk data during READ must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
      end
      if (rd_cyc > 0 && cyc == rd_cyc + 1 + rdelay) begin
        mem_rvalid = 1'b1;
        rv_cyc = cyc;
      end
    end
    mem_rvalid = 1'b0;
    chk({tag, " completed"}, 64'(done_cyc > 0), 64'd1);
    if (trap) begin
      chk({tag, " rd cyc"}, 64'(rd_cyc), 64'(-1));
      chk({tag, " wr cyc"}, 64'(wr_cyc), 64'(-1));
      chk({tag, " done cyc"}, 64'(done_cyc), 64'd1);
    end else if (sub) begin
      chk({tag, " rd cyc"}, 64'(rd_cyc), 64'd1);
      chk({tag, " wr cyc"}, 64'(wr_cyc), 64'(rv_cyc + 1));
      chk({tag, " done cyc"}, 64'(done_cyc), 64'(wr_cyc + 1));
    end else begin
      chk({tag, " rd cyc"}, 64'(rd_cyc), 64'(-1));
      chk({tag, " wr cyc"}, 64'(wr_cyc), 64'd1);
      chk({tag, " done cyc"}, 64'(done_cyc), 64'd2);
    end
  endtask

  initial begin
    int rd0, wr0, dn0;
    reset = 1'b1; req_valid = 1'b0; funct3 = 3'd0; addr = '0; store_data = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    #1;
    chk("rst ready", 64'(req_ready), 64'd1);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst strobes", {61'd0, mem_rd_en, mem_wr_en, done}, 64'd0);
    chk("rst addr", mem_addr, 64'd0);
    chk("rst wdata", mem_wdata, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    exp_q.push_back(64'h1122_3344_AA66_7788);
    do_store("sb", SB, 64'h1003, 64'hAA, 64'h1122_3344_5566_7788, 0, 1'b0, 1'b1, 1'b0);

    exp_q.push_back(64'hBEEF_0000_0000_0000);
    do_store("sh", SH, 64'h2006, 64'hBEEF, 64'h0, 2, 1'b0, 1'b1, 1'b0);

    rd0 = rd_cnt;
    exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    do_store("sd", SD, 64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 1'b0, 1'b0, 1'b0);
    chk("sd no read", 64'(rd_cnt - rd0), 64'd0);

    if (!TRAP) exp_q.push_back(64'h1122_3344_CAFE_BABE);
    do_store("sw misaligned", SW, 64'h4002, 64'hCAFE_BABE, 64'h1122_3344_5566_7788, 1,
             1'b0, 1'b1, TRAP);

    // Upper garbage bits in store_data must not leak into other lanes.
    exp_q.push_back(ref_merge(SB, 64'h7001, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0123_4567_89AB_CDEF));
    do_store("sb garbage", SB, 64'h7001, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0123_4567_89AB_CDEF, 3,
             1'b0, 1'b1, 1'b0);

    // Held request: second acceptance only after done.
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    exp_q.push_back(64'h1234_5678_AAAA_AAAA);
    do_store("hold1", SW, 64'h6004, 64'h1234_5678, 64'hAAAA_AAAA_AAAA_AAAA, 5, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(ref_merge(SW, 64'h6004, 64'h1234_5678, 64'hAAAA_AAAA_AAAA_AAAA));
    do_store("hold2", SW, 64'h6004, 64'h1234_5678, 64'hAAAA_AAAA_AAAA_AAAA, 5, 1'b0, 1'b1, 1'b0);
    chk("hold rd strobes", 64'(rd_cnt - rd0), 64'd2);
    chk("hold wr strobes", 64'(wr_cnt - wr0), 64'd2);
    chk("hold done pulses", 64'(done_cnt - dn0), 64'd2);

    // Reset while waiting for read data.
    @(negedge clk);
    req_valid = 1'b1; funct3 = SH; addr = 64'h5004; store_data = 64'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid read", 64'(mem_rd_en), 64'd1);
    @(negedge clk);
    chk("rstmid waiting", 64'(busy), 64'd1);
    wr0 = wr_cnt; dn0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("rstmid ready", 64'(req_ready), 64'd1);
    chk("rstmid busy", 64'(busy), 64'd0);
    chk("rstmid addr", mem_addr, 64'd0);
    chk("rstmid wdata", mem_wdata, 64'd0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid no write", 64'(wr_cnt - wr0), 64'd0);
    chk("rstmid no done", 64'(done_cnt - dn0), 64'd0);

    exp_q.push_back(ref_merge(SH, 64'h8006, 64'h0000_0000_0000_4321, 64'h5555_5555_5555_5555));
    do_store("post rst sh", SH, 64'h8006, 64'h4321, 64'h5555_5555_5555_5555, 0, 1'b0, 1'b1, 1'b0);

    // Reserved code with funct3[2] set is a full-width store.
    exp_q.push_back(64'h0F0E_0D0C_0B0A_0908);
    do_store("rsvd full", 3'b100, 64'h9000, 64'h0F0E_0D0C_0B0A_0908, 64'h0, 0, 1'b0, 1'b0, 1'b0);

    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
